// File: rtl/ladybird_bus_arbiter_pkg.sv
// ladybird_config: port ids and defaults shared by the ladybird bus arbiter
package ladybird_config;
    typedef enum logic {PORT_D = 1'b0, PORT_I = 1'b1} arb_port_e;
    localparam int ARB_DEFAULT_OUTSTANDING = 2;
endpackage

// File: rtl/ladybird_bus_arbiter_if.sv
// ladybird_bus: request/grant bus with split read-data return (data_gnt/rdata)
interface ladybird_bus #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              gnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
    logic              data_gnt;
    logic [DATA_W-1:0] rdata;
    modport primary (output req, addr, wstrb, wdata, input gnt, data_gnt, rdata);
    modport secondary (input req, addr, wstrb, wdata, output gnt, data_gnt, rdata);
endinterface

// File: rtl/ladybird_bus_arbiter_tag_fifo.sv
// ladybird_arb_tag_fifo: port-id FIFO for accepted reads, same-cycle push+pop
module ladybird_arb_tag_fifo
    import ladybird_config::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  arb_port_e push_tag,
    input  logic      pop,
    output arb_port_e head,
    output logic      full,
    output logic      empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    arb_port_e     tags_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_pop  = pop && !empty;
    // a full FIFO still accepts a push when its head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = tags_q[rd_q];
    always_ff @(posedge clk)
        if (do_push) tags_q[wr_q] <= push_tag;
    always_ff @(posedge clk)
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= bump(wr_q);
            if (do_pop) rd_q <= bump(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/ladybird_bus_arbiter.sv
// ladybird_bus_arbiter: 2:1 arbiter (dbus=port 0, ibus=port 1) with read-tag return routing;
// LADYBIRD_ARB_ROUND_ROBIN_EN selects round robin, otherwise dbus has fixed priority.
module ladybird_bus_arbiter
    import ladybird_config::*;
#(
    parameter int MAX_OUTSTANDING = ARB_DEFAULT_OUTSTANDING,
    parameter int DATA_W          = 32
) (
    input logic              clk,
    input logic              rst,
    ladybird_bus.secondary   dbus,
    ladybird_bus.secondary   ibus,
    ladybird_bus.primary     mem
);
    logic      full, empty, pop, push, room;
    logic      d_rd, i_rd, d_ok, i_ok, sel_d, sel_i, err_q;
    arb_port_e head, push_tag;
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
    arb_port_e prio_q;
    always_ff @(posedge clk)
        if (rst) prio_q <= PORT_D;
        else if (sel_d || sel_i) prio_q <= sel_d ? PORT_I : PORT_D;
`endif
    always_comb begin
        d_rd = dbus.wstrb == '0;
        i_rd = ibus.wstrb == '0;
        pop  = mem.data_gnt && !empty;
        room = !full || pop;
        d_ok = dbus.req && mem.gnt && (!d_rd || room);
        i_ok = ibus.req && mem.gnt && (!i_rd || room);
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
        sel_i = i_ok && (!d_ok || prio_q == PORT_I);
`else
        sel_i = i_ok && !d_ok;
`endif
        sel_d    = d_ok && !sel_i;
        push     = (sel_d && d_rd) || (sel_i && i_rd);
        push_tag = sel_i ? PORT_I : PORT_D;
    end
    assign dbus.gnt  = sel_d;
    assign ibus.gnt  = sel_i;
    assign mem.req   = sel_d || sel_i;
    assign mem.addr  = sel_i ? ibus.addr : sel_d ? dbus.addr : '0;
    assign mem.wstrb = sel_i ? ibus.wstrb : sel_d ? dbus.wstrb : (DATA_W / 8)'(0);
    assign mem.wdata = sel_i ? ibus.wdata : sel_d ? dbus.wdata : DATA_W'(0);
    // responses are steered by the oldest outstanding tag, never reordered
    assign dbus.data_gnt = pop && head == PORT_D;
    assign ibus.data_gnt = pop && head == PORT_I;
    assign dbus.rdata    = mem.rdata;
    assign ibus.rdata    = mem.rdata;
    ladybird_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );
    always_ff @(posedge clk)
        if (rst) err_q <= 1'b0;
        else if (mem.data_gnt && empty) err_q <= 1'b1;
endmodule
